// File: rtl/multi_join_fifo_if.sv
// Handshake bundle for multi_join_fifo.
// Carries per-lane producer signals, the consumer row handshake and the status outputs.
interface multi_join_fifo_if #(
  parameter int unsigned NumFifo   = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8,
  parameter type         dtype     = logic [DataWidth-1:0],
  parameter int unsigned AddrDepth = (Depth > 1) ? $clog2(Depth) : 1
) ();

  dtype [NumFifo-1:0] data_i;
  logic [NumFifo-1:0] valid_i;
  logic [NumFifo-1:0] ready_o;
  dtype [NumFifo-1:0] data_o;
  logic               valid_o;
  logic               ready_i;
  logic               full_o;
  logic               empty_o;
  logic [AddrDepth:0] usage_o;

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output data_o,
    output valid_o,
    input  ready_i,
    output full_o,
    output empty_o,
    output usage_o
  );

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  data_o,
    input  valid_o,
    output ready_i,
    input  full_o,
    input  empty_o,
    input  usage_o
  );

endinterface

// File: rtl/multi_join_fifo.sv
// Multi-lane join FIFO: lanes push independently, complete rows pop as one word.
// Ports: clk_i, rst_ni, flush_i plus bus (slave) carrying lane and row handshakes.
module multi_join_fifo #(
  parameter int unsigned NumFifo   = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8,
  parameter type         dtype     = logic [DataWidth-1:0],
  parameter int unsigned AddrDepth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  multi_join_fifo_if.slave bus
);

  typedef logic [AddrDepth:0]   cnt_t;
  typedef logic [AddrDepth-1:0] idx_t;

  localparam cnt_t DepthC = cnt_t'(Depth);
  localparam cnt_t LastC  = cnt_t'(Depth - 1);

  dtype [NumFifo-1:0] mem_q [Depth];
  dtype [NumFifo-1:0] mem_d [Depth];
  cnt_t [NumFifo-1:0] wp_q, wp_d;
  cnt_t [NumFifo-1:0] cnt_q, cnt_d;
  cnt_t               rp_q, rp_d;

  logic [NumFifo-1:0] ready;
  logic [NumFifo-1:0] push;
  logic               valid;
  logic               full;
  logic               pop;
  cnt_t               usage;

  // Status is derived from registered counts only.
  always_comb begin
    ready = '0;
    valid = 1'b1;
    full  = 1'b0;
    usage = DepthC;
    for (int i = 0; i < NumFifo; i++) begin
      ready[i] = (cnt_q[i] != DepthC);
      valid    = valid & (cnt_q[i] != '0);
      full     = full | (cnt_q[i] == DepthC);
      if (cnt_q[i] < usage) usage = cnt_q[i];
    end
  end

  assign push = bus.valid_i & ready;
  assign pop  = valid & bus.ready_i;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    rp_d  = rp_q;
    if (flush_i) begin
      wp_d  = '0;
      cnt_d = '0;
      rp_d  = '0;
    end else begin
      for (int i = 0; i < NumFifo; i++) begin
        if (push[i]) begin
          mem_d[idx_t'(wp_q[i])][i] = bus.data_i[i];
          wp_d[i] = (wp_q[i] == LastC) ? '0 : wp_q[i] + cnt_t'(1);
        end
        cnt_d[i] = cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop);
      end
      if (pop) rp_d = (rp_q == LastC) ? '0 : rp_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) mem_q[k] <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      rp_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      rp_q  <= rp_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid;
  assign bus.empty_o = ~valid;
  assign bus.full_o  = full;
  assign bus.usage_o = usage;
  assign bus.data_o  = mem_q[idx_t'(rp_q)];

endmodule

// File: doc/multi_join_fifo.md
Name: multi_join_fifo

Overview:
- Gather counterpart of the multi-lane lockstep-pop FIFO. NumFifo producer lanes each push their own element independently, with a per-lane valid/ready handshake; a lane may run ahead of the others by up to Depth entries.
- Row k becomes complete once every lane has written its k-th element. A single consumer then pops the complete row as one NumFifo-wide word.
- Sits where per-lane results (e.g. lane outputs of a vector unit) must be re-joined into one ordered stream for writeback or commit.

Parameters:
- NumFifo, 2, number of producer lanes.
- DataWidth, 32, element width when dtype is left at its default.
- Depth, 8, entries per lane; must be >=1; need not be a power of two.
- dtype, logic [DataWidth-1:0], element type.
- AddrDepth, (Depth>1)?$clog2(Depth):1, derived; must not be overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous clear of all state.
- data_i  in  NumFifo x dtype  per-lane write data.
- valid_i  in  NumFifo  per-lane push request.
- ready_o  out  NumFifo  per-lane space available.
- data_o  out  NumFifo x dtype  head row.
- valid_o  out  1  head row complete.
- ready_i  in  1  consumer accepts head row.
- full_o  out  1  at least one lane is full.
- empty_o  out  1  no complete row present.
- usage_o  out  AddrDepth+1  number of complete rows.

Behaviour:
- **Storage:** mem[Depth][NumFifo].
  - Per-lane write pointer wp[i] and per-lane occupancy cnt[i], each AddrDepth+1 bits wide.
  - One shared read pointer rp.
- **Pointer wrap:** every pointer wraps from Depth-1 to 0.
- **Derived outputs:**
  - ready_o[i] = (cnt[i] != Depth); it depends on registered state only, with no combinational path from ready_i.
  - Lane push occurs when valid_i[i] && ready_o[i]: write mem[wp[i]][i] = data_i[i], advance wp[i], increment cnt[i].
  - valid_o = AND over i of (cnt[i] != 0).
  - usage_o = min over i of cnt[i].
  - empty_o = ~valid_o.
  - full_o = OR over i of (cnt[i] == Depth).
  - data_o = mem[rp], presented every cycle whether or not valid_o is set.
- **Pop:** occurs when valid_o && ready_i. rp advances and every cnt[i] decrements by 1.
- **Simultaneous push and pop on lane i:** cnt[i] is unchanged; both pointers move.
- **No fall-through:** a row becomes visible the cycle after its last lane element is written. Minimum latency from the last lane push to valid_o is 1 cycle.
- **No bypass of full:** space freed by a pop becomes visible on ready_o the next cycle.
- **Ignored requests:** valid_i[i] while ready_o[i]=0, and ready_i while valid_o=0, are ignored with no state change.
- **Reset (rst_ni low, asynchronous):**
  - wp, rp and cnt are all 0; mem is cleared to 0.
  - Resulting outputs: ready_o='1, valid_o=0, empty_o=1, full_o=0, usage_o=0, data_o=0.
- **flush_i:**
  - Next cycle, pointers and counts are in their reset state; mem is not cleared.
  - flush_i has priority: pushes and pops in the flush cycle are discarded.
  - ready_o and valid_o keep reflecting pre-flush state during the flush cycle.
- **Reset mid-operation:** any partial (incomplete) rows are discarded; the block is immediately back in its reset state.
- **Arithmetic:** all counters saturate at no point. By construction cnt[i] stays in 0..Depth; the bench asserts this.
- **Bench assertions:**
  - ready_i is not required to be stable.
  - valid_o, once asserted, stays high until popped; flush and reset are the only exceptions.

Test Plan:
- Reset with NumFifo=2, Depth=4 -> ready_o=2'b11, valid_o=0, empty_o=1, usage_o=0, data_o=0; stays so with no stimulus.
- Lane0 pushes 0xA0 at cycle 0, lane1 pushes 0xA1 at cycle 3 -> valid_o low through cycle 3; at cycle 4 valid_o=1 and data_o={0xA1,0xA0}; ready_i=1 at cycle 4 -> valid_o=0 at cycle 5.
- Lane0 pushes 4 elements, lane1 none -> ready_o[0]=0 and full_o=1 after the 4th push, valid_o=0, usage_o=0; lane1 pushes once -> valid_o=1 and usage_o=1 next cycle; pop -> ready_o[0]=1 the cycle after the pop.
- Depth=3, both lanes stream 10 elements (values 0..9 per lane) with randomized valid_i and ready_i toggling every other cycle -> rows popped in order {n,n}, n=0..9; all pointers wrap 2->0 at least 3 times; no drops or duplicates.
- usage_o=2 with a lane-0 push, a lane-1 push, and a pop in the same cycle -> usage_o stays 2; cnt of each lane unchanged; data_o advances to the next row.
- Lane0 holds 2 elements, lane1 holds 1; assert flush_i together with a lane1 push and ready_i=1 -> next cycle ready_o=2'b11, valid_o=0, usage_o=0; the subsequent first complete row comes only from post-flush pushes.
